// File: rtl/plane_recip.sv
// plane_recip: sequential reciprocal for the checkerboard floor step size.
// Computes floor(2^NUM_SHIFT / denom) with one restoring-division step per
// clock. The result lands exactly RECIP_W+1 cycles after start, which leaves
// margin before the video stage samples it at hblank.
module plane_recip #(
  parameter int DENOM_W   = 10,
  parameter int RECIP_W   = 11,
  parameter int NUM_SHIFT = 16
) (
  input  logic               clk48,
  input  logic               rst,
  input  logic               start,
  input  logic [DENOM_W-1:0] denom,
  output logic [RECIP_W-1:0] recip,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(RECIP_W + 1);

  // Only the low RECIP_W quotient bits are produced. Starting the remainder
  // at 2^NUM_SHIFT >> RECIP_W makes RECIP_W shift-subtract steps equivalent
  // to dividing the full 2^NUM_SHIFT numerator.
  localparam logic [DENOM_W:0]   REM_ONE  = {{DENOM_W{1'b0}}, 1'b1};
  localparam logic [DENOM_W:0]   REM_INIT = REM_ONE << (NUM_SHIFT - RECIP_W);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RECIP_W - 1);
  localparam logic [RECIP_W-1:0] RECIP_SAT = {RECIP_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DENOM_W-1:0] r_den,   w_den_nxt;
  logic [DENOM_W:0]   r_rem,   w_rem_nxt;
  logic [RECIP_W-2:0] r_quo,   w_quo_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_sat,   w_sat_nxt;
  logic [RECIP_W-1:0] r_recip, w_recip_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;

  logic [DENOM_W+1:0] w_shift;
  logic [DENOM_W+1:0] w_trial;
  logic               w_take;
  logic               w_sat_in;

  // Shift-and-trial-subtract datapath for the current iteration.
  always_comb begin
    w_shift = {r_rem, 1'b0};
    w_trial = w_shift - {2'b00, r_den};
    // While the quotient fits, rem < den keeps the shifted value below
    // 2^(DENOM_W+1), so the top bit of the trial is a true sign bit.
    w_take  = ~w_trial[DENOM_W+1];
    // The quotient does not fit when 2^NUM_SHIFT >= denom * 2^RECIP_W,
    // i.e. when denom <= 2^(NUM_SHIFT-RECIP_W); zero also saturates.
    w_sat_in = (denom == {DENOM_W{1'b0}}) || ({1'b0, denom} <= REM_INIT);
  end

  // Next-state and next-register logic; start always wins, even mid-division.
  always_comb begin
    w_state_nxt = r_state;
    w_den_nxt   = r_den;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_cnt_nxt   = r_cnt;
    w_sat_nxt   = r_sat;
    w_recip_nxt = r_recip;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_den_nxt   = denom;
          w_sat_nxt   = w_sat_in;
          w_rem_nxt   = REM_INIT;
          w_quo_nxt   = {(RECIP_W-1){1'b0}};
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_ITER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (start) begin
          // Restart: the operation in flight is dropped without a result.
          w_den_nxt   = denom;
          w_sat_nxt   = w_sat_in;
          w_rem_nxt   = REM_INIT;
          w_quo_nxt   = {(RECIP_W-1){1'b0}};
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_ITER;
        end else begin
          if (w_take) begin
            w_rem_nxt = w_trial[DENOM_W:0];
          end else begin
            w_rem_nxt = w_shift[DENOM_W:0];
          end
          w_quo_nxt = {r_quo[RECIP_W-3:0], w_take};
          if (r_cnt == {CNT_W{1'b0}}) begin
            // Last step: the final quotient bit goes straight into recip.
            if (r_sat) begin
              w_recip_nxt = RECIP_SAT;
            end else begin
              w_recip_nxt = {r_quo, w_take};
            end
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            w_state_nxt = ST_ITER;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_ITER);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_den   <= {DENOM_W{1'b0}};
      r_rem   <= {(DENOM_W+1){1'b0}};
      r_quo   <= {(RECIP_W-1){1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_sat   <= 1'b0;
      r_recip <= {RECIP_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_den   <= w_den_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
      r_recip <= w_recip_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign recip = r_recip;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_plane_recip.sv
// Directed testbench for plane_recip with hand-computed expectations.
module tb_plane_recip;

  logic        clk48;
  logic        rst;
  logic        start;
  logic [9:0]  denom;
  logic [10:0] recip;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int model_recip = 0;

  plane_recip dut (
    .clk48 (clk48),
    .rst   (rst),
    .start (start),
    .denom (denom),
    .recip (recip),
    .busy  (busy),
    .done  (done)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  function automatic int ref_recip(input int d);
    int q;
    if (d == 0) return 2047;
    q = 65536 / d;
    return (q > 2047) ? 2047 : q;
  endfunction

  // One full operation: start in cycle 0, check every cycle through cycle 12.
  task automatic run_op(input int d, input int exp_r);
    tick();
    start = 1'b1;
    denom = d[9:0];
    check("c0_busy", busy, 0);
    check("c0_done", done, 0);
    check("c0_recip", recip, model_recip);
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      denom = 10'($urandom_range(0, 1023));
      if (c < 12) begin
        check("iter_busy", busy, 1);
        check("iter_done", done, 0);
        check("iter_recip_hold", recip, model_recip);
      end else begin
        check("done_busy", busy, 0);
        check("done_pulse", done, 1);
        check("done_recip", recip, exp_r);
      end
    end
    model_recip = exp_r;
  endtask

  initial begin
    int n_done;
    int list[9] = '{27, 33, 64, 100, 255, 256, 300, 511, 512};

    rst   = 1'b0;
    start = 1'b0;
    denom = 10'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_recip", recip, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    tick();
    rst = 1'b0;

    // Basic and sequential operations.
    run_op(64, 1024);
    run_op(300, 218);
    run_op(33, 1985);
    run_op(512, 128);

    // Saturated cases keep the normal latency.
    run_op(32, 2047);
    run_op(0, 2047);

    // Restart while busy: 100 at cycle 0, 200 at cycle 5, single done at 17.
    tick();
    start = 1'b1;
    denom = 10'd100;
    for (int c = 1; c <= 17; c++) begin
      tick();
      start = (c == 5) ? 1'b1 : 1'b0;
      denom = (c == 5) ? 10'd200 : 10'($urandom_range(0, 1023));
      if (c < 17) begin
        check("abort_busy", busy, 1);
        check("abort_no_done", done, 0);
        check("abort_recip_hold", recip, model_recip);
      end else begin
        check("abort_done", done, 1);
        check("abort_recip", recip, 327);
        check("abort_busy_end", busy, 0);
      end
    end
    model_recip = 327;

    // Reset in cycle 6 of a denom=64 operation.
    tick();
    start = 1'b1;
    denom = 10'd64;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_recip", recip, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    model_recip = 0;
    tick();
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) n_done++;
    end
    check("post_rst_dones", n_done, 0);
    check("post_rst_recip", recip, 0);
    run_op(512, 128);

    // Line-loop timing: one start per 1525-cycle line, value still held
    // when the consumer samples it 16 cycles after start.
    for (int i = 0; i < 9; i++) begin
      run_op(list[i], ref_recip(list[i]));
      for (int c = 13; c <= 16; c++) begin
        tick();
      end
      check("line_sample", recip, ref_recip(list[i]));
      for (int c = 17; c < 1525; c++) begin
        tick();
      end
    end

    // Compact sweep over the full floor range.
    for (int d = 27; d <= 512; d++) begin
      run_op(d, ref_recip(d));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plane_recip.md
Name: plane_recip

Overview:
- Sequential reciprocal unit that feeds the per-scanline step size of the 3D checkerboard floor in the VGA demo.
- The video stage pulses start 16 pixel clocks before the end of the active line, presenting plane_y+1. It samples recip at hblank start as the horizontal step (plane_du) for the next line.
- Computes floor(2^NUM_SHIFT / denom) by one-bit-per-cycle restoring division.
- Fixed latency fits inside the 16-cycle window.

Parameters:
- DENOM_W, 10, width of denominator input.
- RECIP_W, 11, width of result; also the number of iteration cycles.
- NUM_SHIFT, 16, numerator is 2^NUM_SHIFT; must satisfy NUM_SHIFT >= RECIP_W.

Ports:
- clk48  input  1  pixel/system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; latches denom.
- denom  input  DENOM_W  unsigned divisor; sampled only in the start cycle.
- recip  output  RECIP_W  registered result; holds last completed value.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; recip updated in this same cycle.

Behaviour:
- Clocking/reset:
  - One clock, clk48.
  - Reset is asynchronous and active-high (rst).
  - While rst is high: recip=0, busy=0, done=0, iteration counter=0, internal remainder/quotient/denominator registers cleared, state=IDLE.
- States:
  - IDLE: busy=0. start=1 -> latch denom, evaluate saturation, load remainder = 2^NUM_SHIFT >> RECIP_W, quotient=0, counter=RECIP_W-1; go to ITER.
  - ITER: busy=1, one step per clock:
    - trial = (rem<<1) - den_latched, with a zero shifted in.
    - If trial is non-negative: rem=trial and quotient bit=1; else rem=rem<<1 and bit=0.
    - Quotient shifts left, MSB first.
    - When counter==0 after this step: write recip, pulse done, go to IDLE.
    - Otherwise decrement the counter.
- Saturation flag, computed once at start and held:
  - Set if denom==0, or if 2^NUM_SHIFT >= denom*2^RECIP_W (true quotient does not fit).
  - If set, the final write gives recip = all ones (2^RECIP_W-1) instead of the quotient.
  - Iterations still run, so latency does not change.
- Latency:
  - Call the start cycle cycle 0.
  - Iterations complete on the edges ending cycles 1..RECIP_W.
  - recip is valid and done=1 in cycle RECIP_W+1 (12 with defaults), in every case.
  - done is high for exactly that one cycle.
- Output stability: recip changes only in the done cycle. At all other times, including during busy, it holds the previous result.
- Start while busy: aborts the current operation and restarts from cycle 0 with the new denom. The aborted operation produces no done and no recip write. busy stays 1.
- Start in the done cycle: the done/recip write for the finishing operation still happens, and the new operation starts.
- denom changes while busy are ignored.
- Arithmetic:
  - Remainder register is DENOM_W+1 bits and unsigned.
  - Subtraction uses DENOM_W+2 bits so the sign can be detected.
  - No rounding: truncate toward zero.
- Reset asserted mid-operation: immediate abort, all outputs 0. No done after reset deasserts until a new start.

Test Plan:
- denom=64 start at cycle 0 -> busy 1 cycles 1..11, done=1 only in cycle 12, recip=1024; recip holds its prior value during cycles 0..11.
- Sequential starts denom=300, then 33, then 512 -> recip=218, then 1985, then 128, each exactly 12 cycles after its start.
- denom=32 and denom=0 -> recip=2047 (saturated), done at cycle 12, same latency as the normal case.
- Start denom=100 at cycle 0, start denom=200 at cycle 5, denom input toggled during busy -> single done at cycle 17, recip=327; no done at cycle 12.
- Assert rst at cycle 6 of a denom=64 operation -> recip=0, busy=0, done=0 immediately; no done after release. Subsequent start denom=512 -> recip=128 after 12 cycles.
- Line-loop model: start every 1525 cycles with denom sweeping 27..512 -> recip equals min(floor(65536/denom), 2047) for every value, and is ready 4 cycles before the consumer samples it.
